// File: rtl/result_window_stats.sv
// Window statistics collector: groups valid samples into WINDOW-sample windows
// and presents sum/min/max/count on a valid/ready port, counting dropped results.
module result_window_stats #(
    parameter int DATA_WIDTH = 8,
    parameter int WINDOW     = 16,
    parameter int DROP_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_valid,
    input  logic                                 flush,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [DATA_WIDTH+$clog2(WINDOW)-1:0] out_sum,
    output logic [DATA_WIDTH-1:0]                out_min,
    output logic [DATA_WIDTH-1:0]                out_max,
    output logic [$clog2(WINDOW+1)-1:0]          out_count,
    output logic                                 overrun,
    input  logic                                 clear_ovr,
    output logic [DROP_WIDTH-1:0]                drop_count
);

    localparam int SW = DATA_WIDTH + $clog2(WINDOW);
    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN_CNT = CW'(WINDOW);

    typedef enum logic {ACC_EMPTY, ACC_ACCUM} acc_state_t;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    acc_state_t            acc_q, acc_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    out_state_t            out_q;
    logic [SW-1:0]         res_sum_q;
    logic [DATA_WIDTH-1:0] res_min_q, res_max_q;
    logic [CW-1:0]         res_cnt_q;
    logic                  overrun_q;
    logic [DROP_WIDTH-1:0] drop_q;

    logic close, accept, drop;

    // The *_d values already fold in the current-cycle sample, so they double
    // as the closed-window result when close fires.
    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            acc_d = ACC_ACCUM;
            if (acc_q == ACC_EMPTY) begin
                sum_d = SW'(in_data);
                min_d = in_data;
                max_d = in_data;
                cnt_d = CW'(1);
            end else begin
                sum_d = sum_q + SW'(in_data);
                if (in_data < min_q) min_d = in_data;
                if (in_data > max_q) max_d = in_data;
                cnt_d = cnt_q + CW'(1);
            end
        end
        close  = (in_valid && (cnt_d == WIN_CNT)) || (flush && (acc_d == ACC_ACCUM));
        accept = (out_q == OUT_EMPTY) || out_ready;
        drop   = close && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= ACC_EMPTY;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            out_q     <= OUT_EMPTY;
            res_sum_q <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
            res_cnt_q <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            sum_q <= sum_d;
            min_q <= min_d;
            max_q <= max_d;
            if (close) begin
                acc_q <= ACC_EMPTY;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end

            if (close && accept) begin
                out_q     <= OUT_FULL;
                res_sum_q <= sum_d;
                res_min_q <= min_d;
                res_max_q <= max_d;
                res_cnt_q <= cnt_d;
            end else if ((out_q == OUT_FULL) && out_ready) begin
                out_q <= OUT_EMPTY;
            end

            // A drop in the same cycle as clear_ovr restarts the count at one.
            if (drop) begin
                overrun_q <= 1'b1;
                if (clear_ovr)        drop_q <= DROP_WIDTH'(1);
                else if (drop_q != '1) drop_q <= drop_q + DROP_WIDTH'(1);
            end else if (clear_ovr) begin
                overrun_q <= 1'b0;
                drop_q    <= '0;
            end
        end
    end

    assign out_valid  = (out_q == OUT_FULL);
    assign out_sum    = res_sum_q;
    assign out_min    = res_min_q;
    assign out_max    = res_max_q;
    assign out_count  = res_cnt_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_q;

endmodule
